// File: rtl/gmii_av_rx.sv
// GMII receive parser: filters UDP/IPv4 frames for this channel and splits the
// payload into a video pixel stream and an aux record stream.
module gmii_av_rx #(
  parameter logic [31:0] IPV4_DST_BASE = 32'hC0A80001,
  parameter logic [15:0] DST_PORT      = 16'd12345,
  parameter int          NUM_CH        = 4,
  parameter int          CH_W          = 2,
  parameter int          PIX_BYTES     = 2,
  parameter int          VID_BYTES     = 1280,
  parameter int          AUX_REC_BYTES = 48,
  parameter int          CNT_W         = 12
) (
  input  logic                      clk125,
  input  logic                      sys_rst,
  input  logic [CH_W-1:0]           id,
  input  logic [7:0]                rxd,
  input  logic                      rx_dv,
  output logic [13+8*PIX_BYTES-1:0] vid_data,
  output logic                      vid_wr_en,
  input  logic                      vid_full,
  output logic [24:0]               aux_data,
  output logic                      aux_wr_en,
  input  logic                      aux_full,
  output logic                      pkt_ok,
  output logic                      err_ovf,
  output logic                      err_trunc,
  output logic [15:0]               drop_cnt
);
  // state  | meaning
  // IDLE   | waiting for rx_dv, byte 0 of a frame
  // HDR    | capturing Ethernet/IPv4/UDP header, accept check at payload byte 0
  // INFO   | payload bytes 1-2: line, field, x_lsb
  // VID    | collecting pixels, one write per PIX_BYTES bytes
  // AUX    | aux records: 2 header bytes then 3-byte sample groups
  // DONE   | frame consumed, ignoring the rest until rx_dv falls
  // SKIP   | filtered out or errored, ignoring the rest until rx_dv falls
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_INFO, S_VID, S_AUX, S_DONE, S_SKIP} state_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int   PIX_W    = 8 * PIX_BYTES;
  localparam cnt_t BC_TYPE  = cnt_t'(50);
  localparam cnt_t BC_P2    = cnt_t'(52);
  localparam cnt_t PIX_LAST = cnt_t'(PIX_BYTES - 1);
  localparam cnt_t VID_LAST = cnt_t'(VID_BYTES - 1);
  localparam cnt_t AUX_LAST = cnt_t'(AUX_REC_BYTES + 1);

  state_t          state, state_nx;
  cnt_t            bc, vcnt, pbyte, acnt;
  logic [1:0]      gcnt;
  logic [CH_W-1:0] id_r;
  logic [15:0]     eth, dport, ulen, aw;
  logic [7:0]      verihl, proto, ptype, aux_b0;
  logic [31:0]     dip;
  logic [10:0]     line_r;
  logic            field_r, xlsb_r;
  logic [3:0]      aux_left;
  logic [PIX_W-1:0] pix, pix_nx;
  logic [16:0]     pend;
  logic            in_pay, hdr_ok;
  logic            vid_we_nx, aux_we_nx, ok_nx, ovf_nx, trunc_nx;
  logic [24:0]     aux_data_nx;

  assign pix_nx = PIX_W'({pix, rxd});
  // payload end: preamble+SFD, MAC header, IPv4 header, then UDP length
  assign pend   = 17'(ulen) + 17'd42;
  assign in_pay = 17'(bc) < pend;
  assign hdr_ok = (eth == 16'h0800) && (verihl == 8'h45) && (proto == 8'h11) &&
                  (dip[31:8] == IPV4_DST_BASE[31:8]) &&
                  (dip[7:0] == (IPV4_DST_BASE[7:0] + 8'(id_r))) &&
                  (dport == DST_PORT) && (32'(id_r) < NUM_CH);

  always_comb begin
    state_nx    = state;
    vid_we_nx   = 1'b0;
    aux_we_nx   = 1'b0;
    ok_nx       = 1'b0;
    ovf_nx      = 1'b0;
    trunc_nx    = 1'b0;
    aux_data_nx = '0;
    if (!rx_dv) begin
      state_nx = S_IDLE;
      trunc_nx = (state == S_INFO) || (state == S_VID) || (state == S_AUX);
    end else begin
      case (state)
        S_IDLE: state_nx = S_HDR;
        S_HDR: begin
          if (bc == BC_TYPE) begin
            if (!hdr_ok) state_nx = S_SKIP;
            else if (!in_pay) begin
              trunc_nx = 1'b1;
              state_nx = S_SKIP;
            end else if (rxd > 8'd2) state_nx = S_SKIP;
            else state_nx = S_INFO;
          end
        end
        S_INFO: begin
          if (!in_pay) begin
            trunc_nx = 1'b1;
            state_nx = S_SKIP;
          end else if (bc == BC_P2) state_nx = (ptype == 8'd1) ? S_AUX : S_VID;
        end
        S_VID: begin
          if (!in_pay) begin
            trunc_nx = 1'b1;
            state_nx = S_SKIP;
          end else if (pbyte == PIX_LAST) begin
            if (vid_full) begin
              ovf_nx   = 1'b1;
              state_nx = S_SKIP;
            end else begin
              vid_we_nx = 1'b1;
              if (vcnt == VID_LAST) begin
                if (ptype == 8'd2) state_nx = S_AUX;
                else begin
                  state_nx = S_DONE;
                  ok_nx    = 1'b1;
                end
              end
            end
          end
        end
        S_AUX: begin
          if (!in_pay) begin
            trunc_nx = 1'b1;
            state_nx = S_SKIP;
          end else if ((acnt == cnt_t'(1)) || ((acnt >= cnt_t'(2)) && (gcnt == 2'd2))) begin
            aux_data_nx = (acnt == cnt_t'(1)) ? {1'b1, rxd, aux_b0, 8'h00} : {1'b0, rxd, aw};
            if (aux_full) begin
              ovf_nx   = 1'b1;
              state_nx = S_SKIP;
            end else begin
              aux_we_nx = 1'b1;
              if ((acnt == AUX_LAST) && (aux_left <= 4'd1)) begin
                state_nx = S_DONE;
                ok_nx    = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk125 or posedge sys_rst) begin
    if (sys_rst) begin
      state <= S_IDLE;
      bc <= '0; vcnt <= '0; pbyte <= '0; acnt <= '0; gcnt <= '0;
      id_r <= '0; eth <= '0; dport <= '0; ulen <= '0; aw <= '0;
      verihl <= '0; proto <= '0; ptype <= '0; aux_b0 <= '0; dip <= '0;
      line_r <= '0; field_r <= 1'b0; xlsb_r <= 1'b0; aux_left <= '0; pix <= '0;
      vid_data <= '0; vid_wr_en <= 1'b0; aux_data <= '0; aux_wr_en <= 1'b0;
      pkt_ok <= 1'b0; err_ovf <= 1'b0; err_trunc <= 1'b0; drop_cnt <= '0;
    end else begin
      state     <= state_nx;
      vid_wr_en <= vid_we_nx;
      aux_wr_en <= aux_we_nx;
      pkt_ok    <= ok_nx;
      err_ovf   <= ovf_nx;
      err_trunc <= trunc_nx;
      if (vid_we_nx) vid_data <= {field_r, line_r, xlsb_r, pix_nx};
      if (aux_we_nx) aux_data <= aux_data_nx;
      if ((ovf_nx || trunc_nx) && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;

      if (!rx_dv) bc <= '0;
      else if (bc != '1) bc <= bc + cnt_t'(1);

      if (rx_dv) begin
        if (state == S_IDLE) id_r <= id;
        case (bc)
          cnt_t'(20): eth[15:8]   <= rxd;
          cnt_t'(21): eth[7:0]    <= rxd;
          cnt_t'(22): verihl      <= rxd;
          cnt_t'(31): proto       <= rxd;
          cnt_t'(38): dip[31:24]  <= rxd;
          cnt_t'(39): dip[23:16]  <= rxd;
          cnt_t'(40): dip[15:8]   <= rxd;
          cnt_t'(41): dip[7:0]    <= rxd;
          cnt_t'(44): dport[15:8] <= rxd;
          cnt_t'(45): dport[7:0]  <= rxd;
          cnt_t'(46): ulen[15:8]  <= rxd;
          cnt_t'(47): ulen[7:0]   <= rxd;
          cnt_t'(50): ptype       <= rxd;
          cnt_t'(51): line_r[7:0] <= rxd;
          cnt_t'(52): begin
            line_r[10:8] <= rxd[2:0];
            field_r      <= rxd[4];
            xlsb_r       <= rxd[5];
            vcnt  <= '0;
            pbyte <= '0;
            acnt  <= '0;
            gcnt  <= '0;
          end
          default: ;
        endcase

        if (state == S_VID) begin
          pix   <= pix_nx;
          pbyte <= (pbyte == PIX_LAST) ? '0 : pbyte + cnt_t'(1);
          vcnt  <= vcnt + cnt_t'(1);
        end

        // acnt walks one record: 0,1 header bytes, then 3-byte groups
        if (state == S_AUX) begin
          if (acnt == '0) aux_b0 <= rxd;
          else if (acnt == cnt_t'(1)) aux_left <= rxd[7:4];
          else begin
            if (gcnt == 2'd0) aw[7:0] <= rxd;
            else if (gcnt == 2'd1) aw[15:8] <= rxd;
            gcnt <= (gcnt == 2'd2) ? 2'd0 : gcnt + 2'd1;
          end
          acnt <= (acnt == AUX_LAST) ? '0 : acnt + cnt_t'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_gmii_av_rx.sv
// Self-checking bench for gmii_av_rx: frame-level scoreboard model plus
// directed frames with literal expectations.
`timescale 1ns/1ps
module tb_gmii_av_rx;
  localparam int PIX_BYTES     = 2;
  localparam int VID_BYTES     = 1280;
  localparam int AUX_REC_BYTES = 48;
  localparam int VW            = 13 + 8 * PIX_BYTES;
  localparam int NPIX          = VID_BYTES / PIX_BYTES;
  localparam int NGRP          = AUX_REC_BYTES / 3;
  localparam int NONE          = 100000;

  logic          clk125 = 1'b0;
  logic          sys_rst = 1'b1;
  logic [1:0]    id = '0;
  logic [7:0]    rxd = '0;
  logic          rx_dv = 1'b0, vid_full = 1'b0, aux_full = 1'b0;
  logic [VW-1:0] vid_data;
  logic [24:0]   aux_data;
  logic          vid_wr_en, aux_wr_en, pkt_ok, err_ovf, err_trunc;
  logic [15:0]   drop_cnt;

  always #4 clk125 = ~clk125;

  gmii_av_rx dut (
    .clk125(clk125), .sys_rst(sys_rst), .id(id), .rxd(rxd), .rx_dv(rx_dv),
    .vid_data(vid_data), .vid_wr_en(vid_wr_en), .vid_full(vid_full),
    .aux_data(aux_data), .aux_wr_en(aux_wr_en), .aux_full(aux_full),
    .pkt_ok(pkt_ok), .err_ovf(err_ovf), .err_trunc(err_trunc), .drop_cnt(drop_cnt)
  );

  int n_chk = 0, n_fail = 0;
  logic [7:0] fb[$];
  bit fv[$], fa[$];
  logic [VW-1:0] exp_vid[$];
  logic [24:0] exp_aux[$], aux_log[$];
  int exp_ok = 0, exp_ovf = 0, exp_trunc = 0, exp_drop = 0;
  int obs_ok = 0, obs_ovf = 0, obs_trunc = 0, n_vid = 0, n_aux = 0;
  logic [VW-1:0] first_vid = '0;
  bit sb_on = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every write is checked against the model's queues
  always @(negedge clk125) begin
    if (sb_on && !sys_rst) begin
      if (vid_wr_en) begin
        n_vid++;
        if (n_vid == 1) first_vid = vid_data;
        if (exp_vid.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL vid_extra: got write %0h expected none", vid_data);
        end else chk("vid_data", 64'(vid_data), 64'(exp_vid.pop_front()));
      end
      if (aux_wr_en) begin
        n_aux++;
        aux_log.push_back(aux_data);
        if (exp_aux.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL aux_extra: got write %0h expected none", aux_data);
        end else chk("aux_data", 64'(aux_data), 64'(exp_aux.pop_front()));
      end
      obs_ok    += int'(pkt_ok);
      obs_ovf   += int'(err_ovf);
      obs_trunc += int'(err_trunc);
    end
  end

  task automatic put(input logic [7:0] b, input bit v = 1'b0, input bit a = 1'b0);
    fb.push_back(b); fv.push_back(v); fa.push_back(a);
  endtask

  task automatic hdr(input logic [7:0] ip_lsb, input logic [15:0] port, input int plen);
    logic [15:0] tl, ul;
    tl = 16'(28 + plen);
    ul = 16'(8 + plen);
    fb.delete(); fv.delete(); fa.delete();
    for (int i = 0; i < 7; i++) put(8'h55);
    put(8'hD5);
    for (int i = 0; i < 12; i++) put(8'h02 + 8'(i));
    put(8'h08); put(8'h00); put(8'h45); put(8'h00); put(tl[15:8]); put(tl[7:0]);
    put(8'h00); put(8'h00); put(8'h40); put(8'h00); put(8'h40); put(8'h11);
    put(8'h00); put(8'h00);
    put(8'hC0); put(8'hA8); put(8'h00); put(8'h64);
    put(8'hC0); put(8'hA8); put(8'h00); put(ip_lsb);
    put(8'h10); put(8'h00); put(port[15:8]); put(port[7:0]);
    put(ul[15:8]); put(ul[7:0]); put(8'h00); put(8'h00);
  endtask

  task automatic info(input logic [7:0] typ, input logic [11:0] line, input bit field, input bit xlsb);
    put(typ); put(line[7:0]); put({2'b00, xlsb, field, line[11:8]});
  endtask

  task automatic vid_bytes(input int full_from_pix);
    for (int k = 0; k < VID_BYTES; k++) put(8'(k), (k / PIX_BYTES) >= full_from_pix);
  endtask

  task automatic aux_rec(input logic [3:0] left, input logic [11:0] rid, input int full_from);
    put(rid[7:0], 1'b0, full_from <= 0);
    put({left, rid[11:8]}, 1'b0, full_from <= 1);
    for (int j = 0; j < AUX_REC_BYTES; j++) put(8'h10 + 8'(j), 1'b0, (j + 2) >= full_from);
  endtask

  task automatic fcs();
    for (int i = 0; i < 4; i++) put(8'hDE);
  endtask

  // frame-level model: parse the byte array directly and list expected writes
  task automatic model(input logic [1:0] cid, input int nsend);
    int pend, avail, pos, res, last;
    logic [7:0] b51, b52, h0, h1;
    logic [10:0] line;
    bit field, xlsb;
    logic [8*PIX_BYTES-1:0] w;
    if (nsend < 51) return;
    if ({fb[20], fb[21]} != 16'h0800 || fb[22] != 8'h45 || fb[31] != 8'h11) return;
    if ({fb[38], fb[39], fb[40], fb[41]} != {24'hC0A800, 8'h01 + 8'(cid)}) return;
    if ({fb[44], fb[45]} != 16'd12345) return;
    pend  = 42 + int'({fb[46], fb[47]});
    avail = (nsend < pend) ? nsend : pend;
    res = 1;
    if (avail <= 50) res = 3;
    else if (fb[50] > 8'd2) return;
    else if (avail <= 52) res = 3;
    b51 = fb[51]; b52 = fb[52];
    line = {b52[2:0], b51}; field = b52[4]; xlsb = b52[5];
    pos = 53;
    if (res == 1 && fb[50] != 8'd1) begin
      for (int k = 0; k < NPIX; k++) begin
        last = pos + PIX_BYTES - 1;
        if (last >= avail) begin res = 3; break; end
        if (fv[last]) begin res = 2; break; end
        w = '0;
        for (int b = 0; b < PIX_BYTES; b++) w = (w << 8) | (8*PIX_BYTES)'(fb[pos + b]);
        exp_vid.push_back({field, line, xlsb, w});
        pos += PIX_BYTES;
      end
    end
    if (res == 1 && fb[50] != 8'd0) begin
      for (int r = 0; r < 64; r++) begin
        if (pos + 1 >= avail) begin res = 3; break; end
        if (fa[pos + 1]) begin res = 2; break; end
        h0 = fb[pos]; h1 = fb[pos + 1];
        exp_aux.push_back({1'b1, h1, h0, 8'h00});
        pos += 2;
        for (int g = 0; g < NGRP; g++) begin
          last = pos + 2;
          if (last >= avail) begin res = 3; break; end
          if (fa[last]) begin res = 2; break; end
          exp_aux.push_back({1'b0, fb[pos + 2], fb[pos + 1], fb[pos]});
          pos += 3;
        end
        if (res != 1 || h1[7:4] <= 4'd1) break;
      end
    end
    case (res)
      1: exp_ok++;
      2: begin exp_ovf++; exp_drop++; end
      default: begin exp_trunc++; exp_drop++; end
    endcase
  endtask

  task automatic send(input int nsend, input int gap);
    for (int i = 0; i < nsend; i++) begin
      @(negedge clk125);
      rxd = fb[i]; rx_dv = 1'b1; vid_full = fv[i]; aux_full = fa[i];
    end
    @(negedge clk125);
    rx_dv = 1'b0; rxd = '0; vid_full = 1'b0; aux_full = 1'b0;
    repeat (gap - 1) @(negedge clk125);
  endtask

  task automatic frame(input logic [1:0] cid, input int nsend, input int gap);
    id = cid;
    model(cid, nsend);
    send(nsend, gap);
  endtask

  task automatic end_check(input string tag);
    repeat (4) @(negedge clk125);
    chk({tag, "_vid_left"}, 64'(exp_vid.size()), 0);
    chk({tag, "_aux_left"}, 64'(exp_aux.size()), 0);
    chk({tag, "_pkt_ok"}, 64'(obs_ok), 64'(exp_ok));
    chk({tag, "_err_ovf"}, 64'(obs_ovf), 64'(exp_ovf));
    chk({tag, "_err_trunc"}, 64'(obs_trunc), 64'(exp_trunc));
    chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(exp_drop));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vid_wr_en"}, 64'(vid_wr_en), 0);
    chk({tag, "_aux_wr_en"}, 64'(aux_wr_en), 0);
    chk({tag, "_vid_data"}, 64'(vid_data), 0);
    chk({tag, "_aux_data"}, 64'(aux_data), 0);
    chk({tag, "_pkt_ok"}, 64'(pkt_ok), 0);
    chk({tag, "_err_ovf"}, 64'(err_ovf), 0);
    chk({tag, "_err_trunc"}, 64'(err_trunc), 0);
    chk({tag, "_drop_cnt"}, 64'(drop_cnt), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk125);
    chk_zero("reset");
    sys_rst = 1'b0;
    @(negedge clk125);

    // type-0, id 1, line 0x123, field 1
    hdr(8'h02, 16'd12345, 3 + VID_BYTES); info(8'd0, 12'h123, 1'b1, 1'b0); vid_bytes(NONE); fcs();
    n_vid = 0;
    frame(2'd1, fb.size(), 3);
    end_check("t1");
    chk("t1_nvid", 64'(n_vid), 640);
    chk("t1_first_vid", 64'(first_vid), 64'h12460001);
    chk("t1_pkt_ok", 64'(obs_ok), 1);

    // filtered out: wrong last octet, wrong port, bad type
    hdr(8'h03, 16'd12345, 3 + VID_BYTES); info(8'd0, 12'h010, 1'b0, 1'b0); vid_bytes(NONE); fcs();
    frame(2'd1, fb.size(), 3);
    hdr(8'h02, 16'd12346, 3 + VID_BYTES); info(8'd0, 12'h010, 1'b0, 1'b0); vid_bytes(NONE); fcs();
    frame(2'd1, fb.size(), 3);
    hdr(8'h02, 16'd12345, 3 + VID_BYTES); info(8'd3, 12'h010, 1'b0, 1'b0); vid_bytes(NONE); fcs();
    frame(2'd1, fb.size(), 3);
    end_check("t2");
    chk("t2_drop_literal", 64'(drop_cnt), 0);

    // type-2: video then two aux records (left 2, then 1)
    hdr(8'h02, 16'd12345, 3 + VID_BYTES + 2 * (AUX_REC_BYTES + 2));
    info(8'd2, 12'h7FF, 1'b0, 1'b1); vid_bytes(NONE);
    aux_rec(4'd2, 12'h534, NONE); aux_rec(4'd1, 12'h0AB, NONE); fcs();
    n_vid = 0; n_aux = 0; aux_log.delete();
    frame(2'd1, fb.size(), 3);
    end_check("t3");
    chk("t3_nvid", 64'(n_vid), 640);
    chk("t3_naux", 64'(n_aux), 34);
    chk("t3_aux_hdr0", 64'(aux_log[0]), 64'h1253400);
    chk("t3_aux_w0", 64'(aux_log[1]), 64'h0121110);
    chk("t3_aux_w1", 64'(aux_log[2]), 64'h0151413);
    chk("t3_aux_hdr1", 64'(aux_log[17]), 64'h110AB00);

    // vid_full from pixel 100 onward
    hdr(8'h02, 16'd12345, 3 + VID_BYTES); info(8'd0, 12'h045, 1'b1, 1'b1); vid_bytes(99); fcs();
    n_vid = 0;
    frame(2'd1, fb.size(), 3);
    end_check("t4");
    chk("t4_nvid", 64'(n_vid), 99);
    chk("t4_drop_literal", 64'(drop_cnt), 1);

    // rx_dv drops at payload byte 700
    hdr(8'h02, 16'd12345, 3 + VID_BYTES); info(8'd0, 12'h200, 1'b0, 1'b0); vid_bytes(NONE); fcs();
    n_vid = 0;
    frame(2'd1, 750, 3);
    end_check("t5");
    chk("t5_nvid", 64'(n_vid), 348);
    chk("t5_drop_literal", 64'(drop_cnt), 2);

    // UDP length ends payload after 100 pixels, frame continues on the wire
    hdr(8'h02, 16'd12345, 3 + 200); info(8'd0, 12'h300, 1'b0, 1'b1); vid_bytes(NONE); fcs();
    n_vid = 0;
    frame(2'd1, fb.size(), 3);
    end_check("t6");
    chk("t6_nvid", 64'(n_vid), 100);

    // back-to-back aux frames on channel 0, 1-cycle gap; second overflows
    hdr(8'h01, 16'd12345, 3 + (AUX_REC_BYTES + 2)); info(8'd1, 12'h000, 1'b0, 1'b0);
    aux_rec(4'd1, 12'hFED, NONE); fcs();
    frame(2'd0, fb.size(), 1);
    hdr(8'h01, 16'd12345, 3 + 2 * (AUX_REC_BYTES + 2)); info(8'd1, 12'h000, 1'b0, 1'b0);
    aux_rec(4'd2, 12'h111, NONE); aux_rec(4'd1, 12'h222, 17); fcs();
    frame(2'd0, fb.size(), 3);
    end_check("t7");

    // reset in the middle of video
    hdr(8'h02, 16'd12345, 3 + VID_BYTES); info(8'd0, 12'h123, 1'b1, 1'b0); vid_bytes(NONE); fcs();
    sb_on = 1'b0;
    id = 2'd1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk125);
      rxd = fb[i]; rx_dv = 1'b1;
    end
    #1 sys_rst = 1'b1;
    #1 chk_zero("t8_rst");
    rx_dv = 1'b0;
    repeat (2) @(negedge clk125);
    sys_rst = 1'b0;
    exp_vid.delete(); exp_aux.delete();
    exp_ok = 0; exp_ovf = 0; exp_trunc = 0; exp_drop = 0;
    obs_ok = 0; obs_ovf = 0; obs_trunc = 0;
    @(negedge clk125);
    sb_on = 1'b1;
    hdr(8'h02, 16'd12345, 3 + VID_BYTES); info(8'd0, 12'h456, 1'b0, 1'b1); vid_bytes(NONE); fcs();
    n_vid = 0;
    frame(2'd1, fb.size(), 3);
    end_check("t8");
    chk("t8_nvid", 64'(n_vid), 640);
    chk("t8_pkt_ok", 64'(obs_ok), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
